// File: rtl/sw_demux_latch.sv
// sw_demux_latch: routes a 4-bit switch word into one of four latched LED channels, or into all four, on a debounced button command
//
// Ports
//   clk  : system clock; all logic updates on its rising edge
//   rst  : asynchronous, active-low reset
//   btn  : btn[0] = WRITE, btn[1] = CLEAR, btn[4:2] are unused
//   sw   : sw[3:0] = data, sw[5:4] = channel select, sw[6] = broadcast, sw[7] is unused
//   ledr : ledr[4i+3:4i] holds channel i, for i = 0..3
module sw_demux_latch #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    output logic [15:0] ledr
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, COMMIT, HOLD} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             cmd, cmd_nx;
    logic [1:0]       btn_m, btn_s;
    logic [6:0]       sw_m, sw_s;

    // The board drives btn and sw asynchronously, so both go through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_m <= '0;
            btn_s <= '0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= btn[1:0];
            btn_s <= btn_m;
            sw_m  <= sw[6:0];
            sw_s  <= sw_m;
        end
    end

    // cmd: 0 = WRITE, 1 = CLEAR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            cmd   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cmd   <= cmd_nx;
        end
    end

    // DEBOUNCE counts cycles with the button high. HOLD counts cycles with both
    // buttons low, so a button that is held down produces only one command.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cmd_nx   = cmd;
        case (state)
            IDLE: if (|btn_s) begin
                cmd_nx   = btn_s[1];
                state_nx = DEBOUNCE;
                cnt_nx   = '0;
            end
            DEBOUNCE: if (!btn_s[cmd]) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (cnt == LAST) begin
                state_nx = COMMIT;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            COMMIT: begin
                state_nx = HOLD;
                cnt_nx   = '0;
            end
            HOLD: if (|btn_s) begin
                cnt_nx = '0;
            end else if (cnt == LAST) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // The channel registers load on the edge that leaves COMMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ledr <= '0;
        else if (state == COMMIT) begin
            if (cmd)
                ledr <= '0;
            else if (sw_s[6])
                ledr <= {4{sw_s[3:0]}};
            else
                ledr[{sw_s[5:4], 2'b00} +: 4] <= sw_s[3:0];
        end
    end
endmodule

// File: tb/tb_sw_demux_latch.sv
// tb_sw_demux_latch: directed scoreboard bench for sw_demux_latch with DB_CYCLES=4
module tb_sw_demux_latch;
    localparam int DB = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btn = '0;
    logic [7:0]  sw = '0;
    logic [15:0] ledr;
    logic [15:0] exp_q[$];
    logic [15:0] prev = '0;
    logic [15:0] model = '0;
    logic [15:0] e;
    bit          mon_on = 1'b0;
    int          total = 0;
    int          bad = 0;

    sw_demux_latch #(.DB_CYCLES(DB), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw), .ledr(ledr)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s ledr=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input logic [15:0] v);
        if (v !== model) exp_q.push_back(v);
        model = v;
    endtask

    task automatic press(input logic [7:0] s, input logic [1:0] b, input int hold,
                         input int rel, input logic [15:0] v, input string tag);
        logic [15:0] old;
        old = model;
        sw  = s;
        btn = {3'b000, b};
        expect_val(v);
        cyc(DB + 3);
        chk({tag, "_pre"}, ledr, old);
        cyc(1);
        chk({tag, "_edge"}, ledr, v);
        cyc(hold - DB - 4);
        btn = '0;
        cyc(rel);
        chk({tag, "_post"}, ledr, v);
    endtask

    always @(negedge clk) begin
        if (mon_on && ledr !== prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL unexpected_change ledr=%h expected=%h", ledr, prev);
            end else begin
                e = exp_q.pop_front();
                assert (ledr === e) else begin
                    bad++;
                    $error("FAIL scoreboard ledr=%h expected=%h", ledr, e);
                end
            end
            prev = ledr;
        end
    end

    initial begin
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn = 5'($urandom);
            sw  = 8'($urandom);
            cyc(1);
            chk("rst_hold", ledr, 16'h0000);
        end
        btn = '0;
        sw  = '0;
        cyc(1);
        rst = 1'b1;
        mon_on = 1'b1;
        cyc(3);
        chk("rst_release", ledr, 16'h0000);

        press(8'h2A, 2'b01, 12, 10, 16'h0A00, "t2_write");

        sw  = 8'h7F;
        btn = 5'b00001;
        cyc(3);
        btn = '0;
        cyc(10);
        chk("t3_glitch", ledr, 16'h0A00);
        for (int i = 0; i < 13; i++) begin
            btn = (i < 3) ? 5'b00001 : 5'b00000;
            sw  = 8'($urandom);
            cyc(1);
        end
        chk("t3_glitch_sw", ledr, 16'h0A00);

        press(8'h45, 2'b01, 12, 10, 16'h5555, "t4_bcast");
        press(8'h45, 2'b10, 12, 10, 16'h0000, "t4_clear");
        press(8'h13, 2'b11, 12, 10, 16'h0000, "t4_both");

        sw  = 8'h01;
        btn = 5'b00001;
        expect_val(16'h0001);
        cyc(DB + 3);
        chk("t5_pre", ledr, 16'h0000);
        cyc(1);
        chk("t5_edge", ledr, 16'h0001);
        cyc(2);
        for (int i = 1; i < 16; i++) begin
            sw = 8'(i);
            cyc(2);
        end
        cyc(10);
        chk("t5_held", ledr, 16'h0001);
        btn = '0;
        cyc(2);
        sw  = 8'h0B;
        btn = 5'b00001;
        cyc(12);
        chk("t5_short_release", ledr, 16'h0001);
        btn = '0;
        cyc(6);
        press(8'h09, 2'b01, 12, 10, 16'h0009, "t5_new");

        sw  = 8'h2C;
        btn = 5'b00001;
        expect_val(16'h0C09);
        cyc(12);
        chk("t6_before_rst", ledr, 16'h0C09);
        expect_val(16'h0000);
        rst = 1'b0;
        #1;
        chk("t6_rst_async", ledr, 16'h0000);
        sw = 8'h37;
        cyc(1);
        rst = 1'b1;
        expect_val(16'h7000);
        cyc(DB + 3);
        chk("t6_pre", ledr, 16'h0000);
        cyc(1);
        chk("t6_edge", ledr, 16'h7000);
        btn = '0;
        cyc(10);
        chk("t6_post", ledr, 16'h7000);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL queue_drain left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
